// File: rtl/if_stage_fetch_if.sv
// Instruction-memory fetch channel: request (valid/ready + address) and response (valid + data).
// Latency: none, this is wiring only; the response arrives one or more cycles after acceptance.
// Backpressure: the requester holds valid/address until ready; responses cannot be stalled.
interface if_stage_fetch_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;

  // Fetch stage side
  modport master (
    output imem_req_valid,
    output imem_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  // Instruction memory side
  modport slave (
    input  imem_req_valid,
    input  imem_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );
endinterface

// File: rtl/if_stage_fetch.sv
// RV32I fetch stage + IF/ID register; owns the PC, one outstanding imem request at a time.
// Latency: an instruction lands in IF/ID on the edge its response is consumed (>=2 cycles per fetch).
// Backpressure: pc_write/if_id_write stalls park the response in a buffer; flush always wins.
// Optional: IF_STAGE_MISALIGN_TRAP_EN adds misalign_err and halts fetch after a misaligned redirect.
module if_stage_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pc_write,
  input  logic                   if_id_write,
  input  logic                   flush,
  input  logic [31:0]            branch_target,
  if_stage_fetch_if.master       imem,
  output logic [31:0]            if_id_pc,
  output logic [31:0]            if_id_instr,
  output logic                   if_id_valid,
  output logic [31:0]            pc_out
`ifdef IF_STAGE_MISALIGN_TRAP_EN
  ,
  output logic                   misalign_err
`endif
);

  // S_HALT is only reachable when the misalignment trap is built in.
  typedef enum logic [2:0] {
    S_REQ  = 3'd0,
    S_WAIT = 3'd1,
    S_HOLD = 3'd2,
    S_DROP = 3'd3,
    S_HALT = 3'd4
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] buf_q, buf_nxt;
  logic [31:0] if_id_pc_nxt, if_id_instr_nxt;
  logic        if_id_valid_nxt;
  logic        err_q, err_nxt;

  logic        req_hs;
  logic        advance;
  logic        deliver;
  logic [31:0] deliver_dat;
  logic [31:0] flush_pc;
  logic        bad_target;

  // Request is only presented in REQ and is masked while reset is held.
  assign imem.imem_req_valid = (state == S_REQ) && !rst;
  assign imem.imem_addr      = pc;
  assign pc_out              = pc;

  assign req_hs   = imem.imem_req_valid && imem.imem_req_ready;
  assign advance  = pc_write && if_id_write;
  // Redirect addresses are always word aligned; the low bits only matter to the trap.
  assign flush_pc = {branch_target[31:2], 2'b00};

`ifdef IF_STAGE_MISALIGN_TRAP_EN
  assign bad_target   = (branch_target[1:0] != 2'b00);
  assign misalign_err = err_q;
`else
  logic unused_target_lsbs;
  assign bad_target         = 1'b0;
  assign unused_target_lsbs = ^{branch_target[1:0], err_q};
`endif

  // Next-state, PC, buffer and IF/ID selection; flush overrides everything below it.
  always_comb begin
    state_nxt       = state;
    pc_nxt          = pc;
    buf_nxt         = buf_q;
    if_id_pc_nxt    = if_id_pc;
    if_id_instr_nxt = if_id_instr;
    if_id_valid_nxt = if_id_valid;
    err_nxt         = err_q;
    deliver         = 1'b0;
    deliver_dat     = NOP_INSTR;

    case (state)
      S_REQ: begin
        if (req_hs) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (imem.imem_rsp_valid) begin
          if (advance) begin
            deliver     = 1'b1;
            deliver_dat = imem.imem_rsp_data;
            state_nxt   = S_REQ;
          end else begin
            buf_nxt   = imem.imem_rsp_data;
            state_nxt = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (advance) begin
          deliver     = 1'b1;
          deliver_dat = buf_q;
          state_nxt   = S_REQ;
        end
      end
      S_DROP: begin
        // The response to the flushed request is swallowed here.
        if (imem.imem_rsp_valid) state_nxt = S_REQ;
      end
      S_HALT: begin
        state_nxt = S_HALT;
      end
      default: begin
        state_nxt = S_REQ;
      end
    endcase

    if (deliver) begin
      if_id_pc_nxt    = pc;
      if_id_instr_nxt = deliver_dat;
      if_id_valid_nxt = 1'b1;
      pc_nxt          = pc + 32'd4;
    end else if (if_id_write && (state != S_HALT)) begin
      if_id_pc_nxt    = pc;
      if_id_instr_nxt = NOP_INSTR;
      if_id_valid_nxt = 1'b0;
    end

    if (flush && (state != S_HALT)) begin
      pc_nxt          = flush_pc;
      buf_nxt         = 32'd0;
      if_id_pc_nxt    = 32'd0;
      if_id_instr_nxt = NOP_INSTR;
      if_id_valid_nxt = 1'b0;
      case (state)
        S_REQ:   state_nxt = req_hs ? S_DROP : S_REQ;
        S_WAIT:  state_nxt = imem.imem_rsp_valid ? S_REQ : S_DROP;
        S_HOLD:  state_nxt = S_REQ;
        default: state_nxt = state_nxt;
      endcase
      if (bad_target) begin
        state_nxt = S_HALT;
        err_nxt   = 1'b1;
      end
    end
  end

  // State, PC, response buffer and IF/ID pipeline register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_REQ;
      pc          <= RESET_PC;
      buf_q       <= 32'd0;
      if_id_pc    <= 32'd0;
      if_id_instr <= NOP_INSTR;
      if_id_valid <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      buf_q       <= buf_nxt;
      if_id_pc    <= if_id_pc_nxt;
      if_id_instr <= if_id_instr_nxt;
      if_id_valid <= if_id_valid_nxt;
      err_q       <= err_nxt;
    end
  end

endmodule

// File: tb/tb_if_stage_fetch.sv
// Randomised bench for if_stage_fetch: random stalls, flushes, memory latency and a mid-run reset.
// Latency: the memory model answers 1..3 cycles after accepting a request.
// Backpressure: imem_req_ready is randomly withheld to exercise request stability.
module tb_if_stage_fetch;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam int          CYCLES   = 3000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pc_write = 1'b0;
  logic        if_id_write = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] branch_target = 32'd0;
  logic [31:0] if_id_pc, if_id_instr, pc_out;
  logic        if_id_valid;
`ifdef IF_STAGE_MISALIGN_TRAP_EN
  logic        misalign_err;
`endif

  if_stage_fetch_if imem ();

  if_stage_fetch #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
    .clk           (clk),
    .rst           (rst),
    .pc_write      (pc_write),
    .if_id_write   (if_id_write),
    .flush         (flush),
    .branch_target (branch_target),
    .imem          (imem),
    .if_id_pc      (if_id_pc),
    .if_id_instr   (if_id_instr),
    .if_id_valid   (if_id_valid),
    .pc_out        (pc_out)
`ifdef IF_STAGE_MISALIGN_TRAP_EN
    ,
    .misalign_err  (misalign_err)
`endif
  );

  always #5 clk = ~clk;

  // Controls applied at one edge; the monitor turns them into the expected IF/ID update.
  typedef struct {
    logic        rst;
    logic        flush;
    logic        ifw;
    logic        pcw;
    logic [31:0] tgt;
  } rec_t;

  rec_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   loads    = 0;

  // Program image: every address holds a distinct word.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hA5C3, a[31:16]} + 32'h0000_0013;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: the reference is the architectural instruction stream -- pc advances by 4
  // per delivered instruction and restarts at the aligned target on each flush.
  logic [31:0] exp_pc = RESET_PC;
  logic [31:0] prev_pc = 32'd0;
  logic [31:0] prev_instr = NOP;
  logic        prev_valid = 1'b0;

  initial begin : monitor
    rec_t r;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() != 0) begin
        r = sb_q.pop_front();
        if (r.rst) begin
          exp_pc = RESET_PC;
          chk("rst_pc_out", pc_out, RESET_PC);
          chk("rst_if_id_pc", if_id_pc, 32'd0);
          chk("rst_if_id_instr", if_id_instr, NOP);
          chk("rst_if_id_valid", {31'd0, if_id_valid}, 32'd0);
          chk("rst_req_valid", {31'd0, imem.imem_req_valid}, 32'd0);
        end else if (r.flush) begin
          exp_pc = r.tgt & ~32'h3;
          chk("flush_if_id_valid", {31'd0, if_id_valid}, 32'd0);
          chk("flush_if_id_instr", if_id_instr, NOP);
          chk("flush_if_id_pc", if_id_pc, 32'd0);
          chk("flush_pc_out", pc_out, exp_pc);
        end else if (!r.ifw) begin
          chk("hold_if_id_pc", if_id_pc, prev_pc);
          chk("hold_if_id_instr", if_id_instr, prev_instr);
          chk("hold_if_id_valid", {31'd0, if_id_valid}, {31'd0, prev_valid});
          chk("hold_pc_out", pc_out, exp_pc);
        end else if (if_id_valid) begin
          chk("deliver_needs_pc_write", {31'd0, r.pcw}, 32'd1);
          chk("deliver_if_id_pc", if_id_pc, exp_pc);
          chk("deliver_if_id_instr", if_id_instr, mem_word(exp_pc));
          exp_pc = exp_pc + 32'd4;
          loads++;
          chk("deliver_pc_out", pc_out, exp_pc);
        end else begin
          chk("bubble_if_id_instr", if_id_instr, NOP);
          chk("bubble_if_id_pc", if_id_pc, exp_pc);
          chk("bubble_pc_out", pc_out, exp_pc);
        end
      end
      prev_pc    = if_id_pc;
      prev_instr = if_id_instr;
      prev_valid = if_id_valid;
    end
  end

  // Stimulus and instruction-memory model.
  initial begin : driver
    bit          pending = 1'b0;
    logic [31:0] p_addr = 32'd0;
    int          lat = 0;
    bit          stalled_req = 1'b0;
    logic [31:0] stalled_addr = 32'd0;
    logic        req_v;
    logic [31:0] req_a;
    bit          warm;

    imem.imem_req_ready = 1'b0;
    imem.imem_rsp_valid = 1'b0;
    imem.imem_rsp_data  = 32'd0;

    for (int cyc = 0; cyc < CYCLES; cyc++) begin
      @(negedge clk);
      warm          = (cyc < 30);
      rst           = (cyc < 3) || (cyc >= 1500 && cyc < 1502);
      flush         = !rst && !warm && ($urandom_range(0, 9) == 0);
      branch_target = $urandom & 32'h0000_0FFF;
`ifdef IF_STAGE_MISALIGN_TRAP_EN
      branch_target[1:0] = 2'b00;
`endif
      pc_write      = warm || ($urandom_range(0, 3) != 0);
      if_id_write   = warm || ($urandom_range(0, 3) != 0);
      imem.imem_rsp_valid = 1'b0;
      #1;
      req_v = imem.imem_req_valid;
      req_a = imem.imem_addr;

      if (stalled_req) begin
        chk("req_stable_valid", {31'd0, req_v}, 32'd1);
        chk("req_stable_addr", req_a, stalled_addr);
      end
      if (req_v) begin
        chk("single_outstanding", {31'd0, pending}, 32'd0);
        chk("req_addr_is_pc", req_a, pc_out);
      end

      if (rst) begin
        pending             = 1'b0;
        imem.imem_req_ready = 1'b0;
      end else begin
        if (pending) begin
          if (lat == 0) begin
            imem.imem_rsp_valid = 1'b1;
            imem.imem_rsp_data  = mem_word(p_addr);
            pending             = 1'b0;
          end else begin
            lat--;
          end
        end
        imem.imem_req_ready = warm ? 1'b1 : ($urandom_range(0, 2) != 0);
        if (req_v && imem.imem_req_ready) begin
          pending = 1'b1;
          p_addr  = req_a;
          lat     = warm ? 0 : int'($urandom_range(0, 2));
        end
      end
      stalled_req  = req_v && !imem.imem_req_ready && !flush && !rst;
      stalled_addr = req_a;
      sb_q.push_back('{rst: rst, flush: flush, ifw: if_id_write, pcw: pc_write, tgt: branch_target});
    end

    @(negedge clk);
    flush = 1'b0;
    imem.imem_rsp_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("progress_min_loads", {31'd0, loads >= 100}, 32'd1);

`ifdef IF_STAGE_MISALIGN_TRAP_EN
    chk("misalign_clear_before", {31'd0, misalign_err}, 32'd0);
    @(negedge clk);
    imem.imem_req_ready = 1'b1;
    flush         = 1'b1;
    branch_target = 32'h0000_0102;
    @(negedge clk);
    flush = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if_id_write = $urandom_range(0, 1) != 0;
      pc_write    = $urandom_range(0, 1) != 0;
      #1;
      chk("misalign_err_sticky", {31'd0, misalign_err}, 32'd1);
      chk("halt_no_request", {31'd0, imem.imem_req_valid}, 32'd0);
      chk("halt_if_id_valid", {31'd0, if_id_valid}, 32'd0);
      chk("halt_if_id_instr", if_id_instr, NOP);
      @(negedge clk);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/if_stage_fetch.md
Name: if_stage_fetch

Overview:
- Instruction-fetch stage plus IF/ID pipeline register of the 5-stage RV32I core.
- Owns the PC and issues one-outstanding-request fetches to instruction memory.
- Honours the hazard unit's pc_write / if_id_write stall controls and the EX-stage branch flush.
- Drives if_id_instr, which the hazard unit decodes for load-use detection.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0) placed in IF/ID on flush/bubble.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-high.
- pc_write  in  1  from hazard unit; 1 = PC may advance.
- if_id_write  in  1  from hazard unit; 1 = IF/ID register may load.
- flush  in  1  branch/jump taken in EX; redirect fetch.
- branch_target  in  32  redirect address, sampled when flush=1.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_addr  out  32  fetch address (= pc).
- imem_rsp_valid  in  1  response data valid; at most one per accepted request, ≥1 cycle after acceptance.
- imem_rsp_data  in  32  fetched instruction.
- if_id_pc  out  32  PC of instruction in IF/ID.
- if_id_instr  out  32  instruction in IF/ID (to decode and hazard unit).
- if_id_valid  out  1  1 = if_id_instr is a real fetched instruction.
- pc_out  out  32  current fetch PC (debug).

Behaviour:
- Reset (rst=1 at posedge):
  - pc=RESET_PC; state=REQ; buffer cleared.
  - if_id_pc=0, if_id_instr=NOP_INSTR, if_id_valid=0.
  - imem_req_valid=0 while rst is high.
- FSM states: REQ, WAIT, HOLD, DROP.
- REQ:
  - imem_req_valid=1, imem_addr=pc.
  - imem_req_ready=1 -> WAIT.
  - Request stays stable until accepted.
- WAIT:
  - imem_req_valid=0.
  - On imem_rsp_valid with pc_write=1 && if_id_write=1: IF/ID <= {pc, rsp_data, valid=1}; pc <= pc+4 (mod 2^32); -> REQ.
  - On imem_rsp_valid with either control low: capture rsp_data into buffer -> HOLD.
- HOLD:
  - imem_req_valid=0.
  - When pc_write=1 && if_id_write=1: IF/ID <= {pc, buffer, 1}; pc <= pc+4; -> REQ.
- Bubble: if_id_write=1 and no instruction delivered this cycle -> IF/ID loads {pc, NOP_INSTR, 0}.
- Hold: if_id_write=0 and no flush -> IF/ID register unchanged.
- Flush has highest priority over stalls and deliveries in every state:
  - pc <= branch_target with bits [1:0] forced to 00.
  - IF/ID <= {0, NOP_INSTR, 0}.
  - Buffer discarded.
- Flush next state:
  - From REQ without handshake, or from HOLD -> REQ.
  - From REQ with handshake in the same cycle, or from WAIT without rsp that cycle -> DROP.
  - From WAIT with rsp in the same cycle -> rsp discarded -> REQ.
- DROP:
  - imem_req_valid=0.
  - Next imem_rsp_valid is discarded -> REQ.
  - A further flush in DROP only updates pc.
- Single outstanding request: no new request is issued until the previous response is consumed or dropped.
- Each accepted request produces exactly one IF/ID load with valid=1, unless it is flushed.

Optional Feature:
- Macro IF_STAGE_MISALIGN_TRAP_EN.
- Defined:
  - Adds output misalign_err (1 bit).
  - A flush with branch_target[1:0]!=0 sets misalign_err, sticky until rst.
  - After that flush, FSM enters a halt state: no further imem requests; IF/ID holds NOP, valid=0.
  - Aligned flushes behave normally.
- Not defined: port absent; branch_target[1:0] ignored (forced 00).

Test Plan:
- Reset then free-run with 1-cycle-latency memory, controls=1 -> requests at 0x0,0x4,0x8; IF/ID shows pc 0x0,0x4,0x8 with valid=1; pc_out reaches 0xC.
- Response 0x00A00093 arrives with if_id_write=pc_write=0 for 2 cycles -> HOLD; IF/ID unchanged; on release, IF/ID = {0x4, 0x00A00093, 1}; no new request during the stall.
- flush=1 with branch_target=0x100 while in WAIT -> IF/ID = NOP, valid=0; the late response for the old PC is dropped; next imem_addr=0x100.
- flush together with pc_write=0 in HOLD -> flush wins; pc=0x100; buffered word never appears in IF/ID.
- rst asserted mid-WAIT -> pc=RESET_PC, if_id_valid=0, imem_req_valid=0 during rst; fetch restarts at RESET_PC.
- With IF_STAGE_MISALIGN_TRAP_EN, flush to 0x102 -> misalign_err=1, no further imem_req_valid until rst.
